// File: rtl/spi_core_arbiter_if.sv
// Requester and spi_core settings-bus signals of the shared SPI arbiter.
// slave: the arbiter side. master: the requesters and core that drive it.
interface spi_core_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0][31:0]   req_data;
    logic [NUM_REQ-1:0]         ack;
    logic [NUM_REQ-1:0]         done;
    logic                       done_err;
    logic [31:0]                rdata;
    logic                       busy;
    logic                       set_stb;
    logic [7:0]                 set_addr;
    logic [31:0]                set_data;
    logic                       core_ready;
    logic [31:0]                core_readback;
    logic                       core_readback_stb;

    modport slave (
        input  req, req_data, core_ready, core_readback, core_readback_stb,
        output ack, done, done_err, rdata, busy, set_stb, set_addr, set_data
    );

    modport master (
        output req, req_data, core_ready, core_readback, core_readback_stb,
        input  ack, done, done_err, rdata, busy, set_stb, set_addr, set_data
    );
endinterface

// File: rtl/spi_core_arbiter.sv
// Round-robin sharing of one spi_core between NUM_REQ requesters, with a
// watchdog that frees the bus when the core never returns its readback strobe.
module spi_core_arbiter_lane (
    input  logic clock,
    input  logic reset,
    input  logic issue_hit,
    input  logic finish_hit,
    output logic ack,
    output logic done
);
    always_ff @(posedge clock) begin
        if (reset) begin
            ack  <= 1'b0;
            done <= 1'b0;
        end else begin
            ack  <= issue_hit;
            done <= finish_hit;
        end
    end
endmodule

module spi_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BASE    = 0,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    spi_core_arbiter_if.slave     bus
);
    localparam int         IDX_W = $clog2(NUM_REQ);
    localparam logic [7:0] ADDR  = 8'(BASE + 2);

    typedef enum logic {IDLE, WAIT_DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } grant_t;

    state_t            state, state_n;
    grant_t            pick;
    logic [IDX_W-1:0]  last;
    logic [TO_W-1:0]   wd;
    logic              issue, finish, expire;

    logic              set_stb_q, set_stb_n;
    logic [7:0]        set_addr_q, set_addr_n;
    logic [31:0]       set_data_q, set_data_n;
    logic              busy_q, busy_n;
    logic              done_err_q, done_err_n;
    logic [31:0]       rdata_q, rdata_n;
    logic [NUM_REQ-1:0] ack_q, done_q;

    // Scan downward so the last hit is the first requester after 'last'.
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (bus.req[IDX_W'(idx)]) begin
                pick.vld = 1'b1;
                pick.idx = IDX_W'(idx);
            end
        end
    end

    generate
        if (TIMEOUT != 0) begin : g_wd
            assign expire = (wd == TO_W'(TIMEOUT - 1));
        end else begin : g_nowd
            assign expire = 1'b0;
        end
    endgenerate

    assign issue  = (state == IDLE) && bus.core_ready && pick.vld;
    // Strobe and expiry on the same cycle both finish; the strobe sets the data.
    assign finish = (state == WAIT_DONE) && (bus.core_readback_stb || expire);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (issue)  state_n = WAIT_DONE;
            WAIT_DONE: if (finish) state_n = IDLE;
        endcase
    end

    always_comb begin
        set_stb_n  = issue;
        set_addr_n = set_addr_q;
        set_data_n = set_data_q;
        busy_n     = busy_q;
        done_err_n = done_err_q;
        rdata_n    = rdata_q;
        if (issue) begin
            set_addr_n = ADDR;
            set_data_n = bus.req_data[pick.idx];
            busy_n     = 1'b1;
        end
        if (finish) begin
            busy_n     = 1'b0;
            done_err_n = ~bus.core_readback_stb;
            rdata_n    = bus.core_readback_stb ? bus.core_readback : 32'h0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            set_stb_q  <= 1'b0;
            set_addr_q <= 8'h0;
            set_data_q <= 32'h0;
            busy_q     <= 1'b0;
            done_err_q <= 1'b0;
            rdata_q    <= 32'h0;
            last       <= IDX_W'(NUM_REQ - 1);
            wd         <= '0;
        end else begin
            set_stb_q  <= set_stb_n;
            set_addr_q <= set_addr_n;
            set_data_q <= set_data_n;
            busy_q     <= busy_n;
            done_err_q <= done_err_n;
            rdata_q    <= rdata_n;
            if (issue) begin
                last <= pick.idx;
                wd   <= '0;
            end else if (state == WAIT_DONE) begin
                wd   <= wd + 1'b1;
            end
        end
    end

    // 'last' doubles as the in-flight grant while waiting for completion.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
            spi_core_arbiter_lane u_lane (
                .clock      (clock),
                .reset      (reset),
                .issue_hit  (issue  && (pick.idx == IDX_W'(i))),
                .finish_hit (finish && (last     == IDX_W'(i))),
                .ack        (ack_q[i]),
                .done       (done_q[i])
            );
        end
    endgenerate

    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign bus.done_err = done_err_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.set_stb  = set_stb_q;
    assign bus.set_addr = set_addr_q;
    assign bus.set_data = set_data_q;
endmodule

// File: tb/tb_spi_core_arbiter.sv
// Directed plus randomized checks of spi_core_arbiter against a queue-free
// round-robin model and a behavioural spi_core driven from the same sequence.
module tb_spi_core_arbiter;
    localparam int N    = 4;
    localparam int BASE = 32;
    localparam int TMO  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    spi_core_arbiter_if #(.NUM_REQ(N)) bus ();

    spi_core_arbiter #(.NUM_REQ(N), .BASE(BASE), .TIMEOUT(TMO), .TO_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          m_last   = N - 1;
    logic [31:0] m_rdata  = 32'h0;
    logic [N-1:0][31:0] m_data;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int g);
        logic [31:0] v;
        v = 32'h0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic int exp_grant(input logic [N-1:0] rq);
        for (int k = 1; k <= N; k++) begin
            if (rq[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_stb"},   32'(bus.set_stb),  32'h0);
        check({tag, "_addr"},  32'(bus.set_addr), 32'h0);
        check({tag, "_data"},  bus.set_data,      32'h0);
        check({tag, "_ack"},   32'(bus.ack),      32'h0);
        check({tag, "_done"},  32'(bus.done),     32'h0);
        check({tag, "_err"},   32'(bus.done_err), 32'h0);
        check({tag, "_rdata"}, bus.rdata,         32'h0);
        check({tag, "_busy"},  32'(bus.busy),     32'h0);
    endtask

    // Issues one request pattern; the granted lane carries word wdat.
    task automatic issue(input logic [N-1:0] rq, input logic [31:0] wdat, output int g);
        g = exp_grant(rq);
        for (int i = 0; i < N; i++) m_data[i] = $urandom;
        if (g >= 0) m_data[g] = wdat;
        bus.req_data   = m_data;
        bus.req        = rq;
        bus.core_ready = 1'b1;
        tick();
        check("issue_stb",  32'(bus.set_stb),  32'h1);
        check("issue_ack",  32'(bus.ack),      oh(g));
        check("issue_addr", 32'(bus.set_addr), 32'(BASE + 2));
        check("issue_data", bus.set_data,      wdat);
        check("issue_busy", 32'(bus.busy),     32'h1);
        m_last = g;
        bus.req[g] = 1'b0;
    endtask

    // lat = cycles from the set_stb cycle to the cycle the core strobes.
    task automatic transfer(input logic [N-1:0] rq, input logic [31:0] wdat,
                            input int lat, input logic [31:0] rb);
        int g;
        issue(rq, wdat, g);
        for (int c = 1; c < lat; c++) begin
            bus.req = N'($urandom);
            tick();
            check("wait_done", 32'(bus.done),     32'h0);
            check("wait_stb",  32'(bus.set_stb),  32'h0);
            check("wait_ack",  32'(bus.ack),      32'h0);
            check("wait_addr", 32'(bus.set_addr), 32'(BASE + 2));
        end
        bus.core_readback     = rb;
        bus.core_readback_stb = 1'b1;
        tick();
        bus.core_readback_stb = 1'b0;
        bus.req               = '0;
        check("done_vec",   32'(bus.done),     oh(g));
        check("done_err",   32'(bus.done_err), 32'h0);
        check("done_rdata", bus.rdata,         rb);
        check("done_busy",  32'(bus.busy),     32'h0);
        m_rdata = rb;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        bus.req = '0; bus.req_data = '0; bus.core_ready = 1'b0;
        bus.core_readback = 32'h0; bus.core_readback_stb = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_reset_outs("por");

        // Single request with the documented words
        transfer(4'b0001, 32'h00A5_5A00, 3, 32'h0012_3456);

        // Round robin: everyone asks, each reasserts after done -> 1,2,3,0,1
        for (int k = 0; k < 5; k++) transfer(4'b1111, $urandom, 2, $urandom);
        // last is now 1: 1010 grants 3 then 1
        transfer(4'b1010, $urandom, 1, $urandom);
        transfer(4'b1010, $urandom, 4, $urandom);

        // Core not ready: nothing issues until ready rises
        bus.core_ready = 1'b0;
        bus.req        = 4'b0100;
        for (int c = 0; c < 50; c++) begin
            tick();
            check("notready_stb", 32'(bus.set_stb), 32'h0);
        end
        check("notready_busy", 32'(bus.busy), 32'h0);
        transfer(4'b0100, $urandom, 2, $urandom);

        // Watchdog abort 16 cycles after the set_stb cycle
        issue(4'b0010, $urandom, g);
        for (int c = 1; c < TMO; c++) begin
            tick();
            check("wd_wait_done", 32'(bus.done), 32'h0);
            check("wd_wait_busy", 32'(bus.busy), 32'h1);
        end
        tick();
        check("wd_done",  32'(bus.done),     oh(g));
        check("wd_err",   32'(bus.done_err), 32'h1);
        check("wd_rdata", bus.rdata,         32'h0);
        check("wd_busy",  32'(bus.busy),     32'h0);
        m_rdata = 32'h0;
        tick();
        check("wd_done_pulse", 32'(bus.done), 32'h0);

        // Strobe on the expiry cycle wins
        transfer(4'b1000, $urandom, TMO, 32'hCAFE_F00D);

        // Stray strobe in IDLE is ignored
        bus.core_readback     = 32'h1357_9BDF;
        bus.core_readback_stb = 1'b1;
        tick();
        bus.core_readback_stb = 1'b0;
        tick();
        check("stray_done",  32'(bus.done), 32'h0);
        check("stray_rdata", bus.rdata,     m_rdata);
        check("stray_busy",  32'(bus.busy), 32'h0);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            transfer(N'($urandom_range(1, 15)), $urandom, $urandom_range(1, TMO), $urandom);
        end

        // Reset 5 cycles into a transfer
        issue(4'b1111, $urandom, g);
        bus.req = '0;
        for (int c = 0; c < 5; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outs("midrst");
        tick();
        check("midrst_nodone", 32'(bus.done), 32'h0);
        m_last = N - 1;
        transfer(4'b1111, 32'h0BAD_BEEF, 2, 32'h7777_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
